// File: rtl/multi_scan_chain_if.sv
// Purpose: data/handshake bundle between the bitstream loader, the scan chains and the readback consumer.
// Latency: wires only, no storage.
// Backpressure: load side is valid_i/ready_o, readback side is valid_o/ready_i.
//
// Ports (signals):
//   data_i  [NUM_CHAINS]  load bit per chain (bit c feeds chain c)
//   valid_i               data_i valid (load mode)
//   ready_o               chain accepts data_i (load mode, SHIFT)
//   data_o  [NUM_CHAINS]  LSB of each chain, continuously
//   valid_o               data_o valid for readback (readback mode, SHIFT)
//   ready_i               consumer accepts data_o
interface multi_scan_chain_if #(
  parameter int NUM_CHAINS = 4
);
  logic [NUM_CHAINS-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [NUM_CHAINS-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  // Loader / consumer side.
  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  // Scan chain side.
  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/multi_scan_chain.sv
// Purpose: NUM_CHAINS parallel SC_LENGTH-bit configuration shift chains with handshaked load, rotating readback, parity.
// Latency: one shift per accepted beat; done pulses the cycle after the SC_LENGTH-th shift, busy drops one cycle later.
// Backpressure: valid_i low (load) or ready_i low (readback) stalls the chain indefinitely; no timeout.
//
// Ports:
//   clk        clock, rising edge
//   clear      synchronous active-high reset, overrides everything
//   start      begin a sequence (sampled in IDLE only); mode latched with it: 0 load, 1 readback
//   abort      terminate an active SHIFT; wins over a same-cycle shift
//   bus        multi_scan_chain_if.slave data/handshake bundle
//   busy       FSM not in IDLE
//   done       one-cycle pulse after a completed sequence
//   aborted    one-cycle pulse after an abort
//   bit_count  shifts completed in the current or last sequence (saturates at SC_LENGTH)
//   parity_o   per-chain XOR of all bits shifted in by the last load
module multi_scan_chain #(
  parameter int NUM_CHAINS = 4,
  parameter int SC_LENGTH  = 128
) (
  input  logic                               clk,
  input  logic                               clear,
  input  logic                               start,
  input  logic                               mode,
  input  logic                               abort,
  multi_scan_chain_if.slave                  bus,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted,
  output logic [$clog2(SC_LENGTH+1)-1:0]     bit_count,
  output logic [NUM_CHAINS-1:0]              parity_o
);

  localparam int CW = $clog2(SC_LENGTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SC_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                                  mode_q;     // 0 load, 1 readback
  logic                                  aborted_q;
  logic                                  shift_en;
  logic [NUM_CHAINS-1:0][SC_LENGTH-1:0]  chain_q;

  // State register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake outputs and the shift strobe.
  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy        = 1'b1;
        bus.ready_o = ~mode_q;
        bus.valid_o = mode_q;
        if (abort) begin
          // Abort suppresses any shift offered in the same cycle.
          state_d = IDLE;
        end else begin
          shift_en = mode_q ? bus.ready_i : bus.valid_i;
          if (shift_en && (bit_count == LAST_CNT)) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Chain storage, bit counter, parity and the abort pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      mode_q    <= 1'b0;
      aborted_q <= 1'b0;
      chain_q   <= '0;
      bit_count <= '0;
      parity_o  <= '0;
    end else begin
      aborted_q <= (state_q == SHIFT) && abort;
      if ((state_q == IDLE) && start) begin
        mode_q    <= mode;
        bit_count <= '0;
        // Readback leaves the parity of the last load visible.
        if (!mode) parity_o <= '0;
      end
      if (shift_en) begin
        bit_count <= bit_count + CW'(1);
        for (int c = 0; c < NUM_CHAINS; c++) begin
          if (mode_q) begin
            // Rotate: LSB re-enters at the MSB so SC_LENGTH shifts restore the chain.
            chain_q[c] <= {chain_q[c][0], chain_q[c][SC_LENGTH-1:1]};
          end else begin
            chain_q[c]  <= {bus.data_i[c], chain_q[c][SC_LENGTH-1:1]};
            parity_o[c] <= parity_o[c] ^ bus.data_i[c];
          end
        end
      end
    end
  end

  assign aborted = aborted_q;

  always_comb begin
    bus.data_o = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      bus.data_o[c] = chain_q[c][0];
    end
  end

endmodule
